lane_scrambler: RTL and testbench



---
 rtl/lane_scrambler.sv | 128 ++++++++++++
 tb/tb_lane_scrambler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_scrambler.sv
// Two-lane bit-serial scrambler/descrambler, LFSR x^23+x^21+x^16+x^8+x^5+x^2+1, sync headers bypassed.
// Define LANE_SCR_ERR_CNT_EN to add per-lane RX payload error counters (prbs_check, err_cnt_l0/l1).
module lane_scrambler #(
    parameter int unsigned BLOCK_BITS = 132,
    parameter int unsigned HDR_BITS   = 4,
    parameter logic [22:0] SEED_L0    = 23'h1DBFBC,
    parameter logic [22:0] SEED_L1    = 23'h0607BB
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scr_rst,
    input  logic       enable_scr,
    input  logic       lane_0_tx_i,
    input  logic       lane_1_tx_i,
    output logic       lane_0_tx_o,
    output logic       lane_1_tx_o,
    input  logic       descr_rst,
    input  logic       enable_descr,
    input  logic       lane_0_rx_i,
    input  logic       lane_1_rx_i,
    output logic       lane_0_rx_o,
`ifdef LANE_SCR_ERR_CNT_EN
    input  logic       prbs_check,
    output logic [7:0] err_cnt_l0,
    output logic [7:0] err_cnt_l1,
`endif
    output logic       lane_1_rx_o
);

    localparam logic [7:0] HdrBits = 8'(HDR_BITS);
    localparam logic [7:0] BlkLast = 8'(BLOCK_BITS - 1);

    // Channel index: 0 = TX0, 1 = TX1, 2 = RX0, 3 = RX1; odd channels are lane 1.
    logic [3:0]  strobe, enable, din;
    logic [3:0]  out_q, out_d;
    logic [22:0] lfsr_q [4];
    logic [22:0] lfsr_d [4];
    logic [7:0]  cnt_q  [4];
    logic [7:0]  cnt_d  [4];

    assign strobe = {descr_rst, descr_rst, scr_rst, scr_rst};
    assign enable = {enable_descr, enable_descr, enable_scr, enable_scr};
    assign din    = {lane_1_rx_i, lane_0_rx_i, lane_1_tx_i, lane_0_tx_i};

    function automatic logic [22:0] seed_of(input int ch);
        return ch[0] ? SEED_L1 : SEED_L0;
    endfunction

    function automatic logic [22:0] lfsr_next(input logic [22:0] s);
        return {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
    endfunction

    always_comb begin
        for (int ch = 0; ch < 4; ch++) begin
            lfsr_d[ch] = lfsr_q[ch];
            cnt_d[ch]  = cnt_q[ch];
            out_d[ch]  = 1'b0;
            if (strobe[ch]) begin
                lfsr_d[ch] = seed_of(ch);
                cnt_d[ch]  = '0;
            end else if (enable[ch]) begin
                cnt_d[ch] = (cnt_q[ch] == BlkLast) ? 8'd0 : cnt_q[ch] + 8'd1;
                if (cnt_q[ch] < HdrBits) begin
                    out_d[ch] = din[ch];
                end else begin
                    out_d[ch]  = din[ch] ^ lfsr_q[ch][22];
                    lfsr_d[ch] = lfsr_next(lfsr_q[ch]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                lfsr_q[ch] <= seed_of(ch);
                cnt_q[ch]  <= '0;
            end
            out_q <= '0;
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                lfsr_q[ch] <= lfsr_d[ch];
                cnt_q[ch]  <= cnt_d[ch];
            end
            out_q <= out_d;
        end
    end

    assign lane_0_tx_o = out_q[0];
    assign lane_1_tx_o = out_q[1];
    assign lane_0_rx_o = out_q[2];
    assign lane_1_rx_o = out_q[3];

`ifdef LANE_SCR_ERR_CNT_EN
    logic [7:0] err_q [2];
    logic [7:0] err_d [2];
    logic       rx_payload;

    // Only descrambled payload bits count; a strobe cycle discards its input bit.
    assign rx_payload = enable_descr && !descr_rst && (cnt_q[2] >= HdrBits);

    always_comb begin
        for (int ln = 0; ln < 2; ln++) begin
            err_d[ln] = '0;
            if (prbs_check) begin
                err_d[ln] = err_q[ln];
                if (rx_payload && out_d[2 + ln] && (err_q[ln] != 8'hFF)) begin
                    err_d[ln] = err_q[ln] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q[0] <= '0;
            err_q[1] <= '0;
        end else begin
            err_q[0] <= err_d[0];
            err_q[1] <= err_d[1];
        end
    end

    assign err_cnt_l0 = err_q[0];
    assign err_cnt_l1 = err_q[1];
`endif

endmodule

// File: tb/tb_lane_scrambler.sv
// Directed self-checking bench for lane_scrambler; error-counter steps run when
// LANE_SCR_ERR_CNT_EN is defined.
module tb_lane_scrambler;

    localparam logic [22:0] SeedL0 = 23'h1DBFBC;
    localparam logic [22:0] SeedL1 = 23'h0607BB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, scr_rst, enable_scr, descr_rst, enable_descr;
    logic l0_tx_i, l1_tx_i, l0_tx_o, l1_tx_o;
    logic l0_rx_i, l1_rx_i, l0_rx_o, l1_rx_o;
    logic rx0_drv, rx1_drv, loop_en;
`ifdef LANE_SCR_ERR_CNT_EN
    logic       prbs_check;
    logic [7:0] err_cnt_l0, err_cnt_l1;
`endif

    // Loopback wires TX outputs straight to RX inputs.
    assign l0_rx_i = loop_en ? l0_tx_o : rx0_drv;
    assign l1_rx_i = loop_en ? l1_tx_o : rx1_drv;

    lane_scrambler dut (
        .clk          (clk),
        .rst          (rst),
        .scr_rst      (scr_rst),
        .enable_scr   (enable_scr),
        .lane_0_tx_i  (l0_tx_i),
        .lane_1_tx_i  (l1_tx_i),
        .lane_0_tx_o  (l0_tx_o),
        .lane_1_tx_o  (l1_tx_o),
        .descr_rst    (descr_rst),
        .enable_descr (enable_descr),
        .lane_0_rx_i  (l0_rx_i),
        .lane_1_rx_i  (l1_rx_i),
        .lane_0_rx_o  (l0_rx_o),
`ifdef LANE_SCR_ERR_CNT_EN
        .prbs_check   (prbs_check),
        .err_cnt_l0   (err_cnt_l0),
        .err_cnt_l1   (err_cnt_l1),
`endif
        .lane_1_rx_o  (l1_rx_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [22:0] k0, k1, v0, v1, rk0, rk1;
    logic        diff, d0, d1;
    logic [3:0]  hdr0, hdr1;
    logic        hist0 [396];
    logic        hist1 [396];
    int          rcnt;

    function automatic logic [22:0] adv(input logic [22:0] s);
        return {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one RX bit whose descrambled value should be {f1,f0}.
    task automatic rx_send(input logic f0, input logic f1);
        if (rcnt < 4) begin
            rx0_drv = f0;
            rx1_drv = f1;
        end else begin
            rx0_drv = f0 ^ rk0[22];
            rx1_drv = f1 ^ rk1[22];
            rk0 = adv(rk0);
            rk1 = adv(rk1);
        end
        rcnt = (rcnt == 131) ? 0 : rcnt + 1;
        enable_descr = 1'b1;
        tick();
        chk("rx_descr", 32'({l1_rx_o, l0_rx_o}), 32'({f1, f0}));
    endtask

    initial begin
        rst = 1'b1; scr_rst = 1'b0; enable_scr = 1'b0; descr_rst = 1'b0; enable_descr = 1'b0;
        l0_tx_i = 1'b0; l1_tx_i = 1'b0; rx0_drv = 1'b0; rx1_drv = 1'b0; loop_en = 1'b0;
`ifdef LANE_SCR_ERR_CNT_EN
        prbs_check = 1'b0;
`endif

        // Reset dominates toggling inputs.
        for (int i = 0; i < 6; i++) begin
            {scr_rst, enable_scr, l0_tx_i, l1_tx_i, descr_rst, enable_descr, rx0_drv, rx1_drv} =
                8'($urandom);
            tick();
            chk("reset_out", 32'({l1_rx_o, l0_rx_o, l1_tx_o, l0_tx_o}), 32'd0);
        end
        rst = 1'b0; scr_rst = 1'b0; descr_rst = 1'b0; enable_scr = 1'b0; enable_descr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            {l0_tx_i, l1_tx_i, rx0_drv, rx1_drv} = 4'($urandom);
            tick();
            chk("idle_out", 32'({l1_rx_o, l0_rx_o, l1_tx_o, l0_tx_o}), 32'd0);
        end

        // Strobe with enable: input discarded.
        scr_rst = 1'b1; enable_scr = 1'b1; l0_tx_i = 1'b1; l1_tx_i = 1'b1;
        tick();
        chk("strobe_out", 32'({l1_tx_o, l0_tx_o}), 32'd0);
        scr_rst = 1'b0;

        // Header pass-through.
        hdr0 = 4'b1010;
        hdr1 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            l0_tx_i = hdr0[3-i];
            l1_tx_i = hdr1[3-i];
            tick();
            chk("hdr_tx", 32'({l1_tx_o, l0_tx_o}), 32'({hdr1[3-i], hdr0[3-i]}));
        end

        // Payload key stream with zero input.
        k0 = SeedL0; k1 = SeedL1; v0 = '0; v1 = '0; diff = 1'b0;
        l0_tx_i = 1'b0; l1_tx_i = 1'b0;
        for (int i = 0; i < 128; i++) begin
            tick();
            chk("key_l0", 32'(l0_tx_o), 32'(k0[22]));
            chk("key_l1", 32'(l1_tx_o), 32'(k1[22]));
            if (i < 23) begin
                v0 = {v0[21:0], l0_tx_o};
                v1 = {v1[21:0], l1_tx_o};
            end
            if (l0_tx_o !== l1_tx_o) diff = 1'b1;
            k0 = adv(k0);
            k1 = adv(k1);
        end
        chk("first_pay_bit", 32'({v1[22], v0[22]}), 32'd0);
        chk("first23_l0", 32'(v0), 32'h1DBFBC);
        chk("first23_l1", 32'(v1), 32'h0607BB);
        chk("lanes_differ", 32'(diff), 32'd1);

        // Block wrap without strobe: header again, then key continues.
        hdr0 = 4'b1100;
        hdr1 = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            l0_tx_i = hdr0[3-i];
            l1_tx_i = hdr1[3-i];
            tick();
            chk("wrap_hdr", 32'({l1_tx_o, l0_tx_o}), 32'({hdr1[3-i], hdr0[3-i]}));
        end
        for (int i = 0; i < 10; i++) begin
            d0 = 1'($urandom); d1 = 1'($urandom);
            l0_tx_i = d0; l1_tx_i = d1;
            tick();
            chk("wrap_pay", 32'({l1_tx_o, l0_tx_o}), 32'({d1 ^ k1[22], d0 ^ k0[22]}));
            k0 = adv(k0);
            k1 = adv(k1);
        end

        // Gap of 7 cycles mid-payload, then resume with no skipped key bit.
        enable_scr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            {l0_tx_i, l1_tx_i} = 2'($urandom);
            tick();
            chk("gap_out", 32'({l1_tx_o, l0_tx_o}), 32'd0);
        end
        enable_scr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d0 = 1'($urandom); d1 = 1'($urandom);
            l0_tx_i = d0; l1_tx_i = d1;
            tick();
            chk("resume_pay", 32'({l1_tx_o, l0_tx_o}), 32'({d1 ^ k1[22], d0 ^ k0[22]}));
            k0 = adv(k0);
            k1 = adv(k1);
        end

        // Strobe collision mid-payload: discard, reseed, restart count.
        scr_rst = 1'b1; l0_tx_i = 1'b1; l1_tx_i = 1'b1;
        tick();
        chk("collide_out", 32'({l1_tx_o, l0_tx_o}), 32'd0);
        scr_rst = 1'b0;
        l0_tx_i = 1'b0; l1_tx_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("collide_hdr", 32'({l1_tx_o, l0_tx_o}), 32'd0);
        end
        k0 = SeedL0; k1 = SeedL1;
        for (int i = 0; i < 23; i++) begin
            tick();
            chk("reseed_key", 32'({l1_tx_o, l0_tx_o}), 32'({k1[22], k0[22]}));
            k0 = adv(k0);
            k1 = adv(k1);
        end

        // Loopback over 3 blocks; RX strobe one cycle after TX strobe.
        loop_en = 1'b1;
        scr_rst = 1'b1; enable_scr = 1'b0;
        tick();
        scr_rst = 1'b0;
        for (int i = 0; i <= 396; i++) begin
            descr_rst    = (i == 0);
            enable_scr   = (i < 396);
            enable_descr = (i >= 1);
            if (i < 396) begin
                hist0[i] = 1'($urandom);
                hist1[i] = 1'($urandom);
                l0_tx_i  = hist0[i];
                l1_tx_i  = hist1[i];
            end
            tick();
            if (i >= 1) begin
                chk("loopback", 32'({l1_rx_o, l0_rx_o}), 32'({hist1[i-1], hist0[i-1]}));
            end
        end
        loop_en = 1'b0; enable_scr = 1'b0; enable_descr = 1'b0; descr_rst = 1'b0;

`ifdef LANE_SCR_ERR_CNT_EN
        prbs_check = 1'b0;
        tick();
        chk("err_clr_l0", 32'(err_cnt_l0), 32'd0);
        chk("err_clr_l1", 32'(err_cnt_l1), 32'd0);
        prbs_check = 1'b1;
        descr_rst = 1'b1; enable_descr = 1'b1;
        tick();
        descr_rst = 1'b0;
        rk0 = SeedL0; rk1 = SeedL1; rcnt = 0;
        for (int i = 0; i < 132; i++) begin
            rx_send(1'b0, (i == 1) || (i == 10) || (i == 50) || (i == 100));
        end
        chk("err_l0_zero", 32'(err_cnt_l0), 32'd0);
        chk("err_l1_three", 32'(err_cnt_l1), 32'd3);
        for (int i = 0; i < 340; i++) begin
            rx_send(1'b0, 1'b1);
        end
        chk("err_l0_sat_zero", 32'(err_cnt_l0), 32'd0);
        chk("err_l1_sat", 32'(err_cnt_l1), 32'hFF);
        prbs_check = 1'b0; enable_descr = 1'b0;
        tick();
        chk("err_l1_drop", 32'(err_cnt_l1), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
